// File: rtl/mac_share_pkg.sv
// Shared widths and payload types for the shared multiply-add arbiter.
package mac_share_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned LAT            = 2;
    localparam int unsigned FIFO_DEPTH_DEF = 3;
    localparam int unsigned ID_W           = $clog2(N_REQ_DEF);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        id_t                   id;
        logic [DATA_W_DEF-1:0] data;
    } resp_t;

endpackage

// File: rtl/mac_pipe.sv
// Two-stage non-stallable datapath: stage 1 registers A*B, stage 2 adds C.
// A valid/tag shift register travels alongside the data.
module mac_pipe
    import mac_share_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    output logic [LAT-1:0]    stage_valid_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DATA_W-1:0] prod_d, prod_q, addend_q, sum_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q;
    logic              v1_q, v2_q;

    // Product is kept only modulo 2^DATA_W; the upper half never matters.
    assign prod_d = a_i * b_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            addend_q <= '0;
            sum_q    <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            addend_q <= c_i;
            tag1_q   <= in_tag_i;
            v1_q     <= in_valid_i;
            sum_q    <= prod_q + addend_q;
            tag2_q   <= tag1_q;
            v2_q     <= v1_q;
        end
    end

    assign stage_valid_o = {v2_q, v1_q};
    assign out_tag_o     = tag2_q;
    assign out_data_o    = sum_q;

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin front end sharing one mac_pipe among N_REQ requesters, with a
// credit-limited result FIFO so the unstallable pipe can never overflow it.
module mac_share_arbiter
    import mac_share_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned TAG_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*DATA_W-1:0] req_a_i,
    input  logic [N_REQ*DATA_W-1:0] req_b_i,
    input  logic [N_REQ*DATA_W-1:0] req_c_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [TAG_W-1:0]        resp_id_o,
    output logic [DATA_W-1:0]       resp_data_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [TAG_W-1:0]  rr_q, rr_d, grant_idx;
    logic [TAG_W:0]    cand;
    logic              grant_found, issue_ok, accept, pop, pipe_valid;
    logic [DATA_W-1:0] sel_a, sel_b, sel_c;
    logic [LAT-1:0]    stage_valid;
    logic [TAG_W-1:0]  pipe_tag;
    logic [DATA_W-1:0] pipe_data;
    logic [CNT_W:0]    occ;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0]  mem_id_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];

    assign resp_valid_o = (fifo_cnt_q != '0);
    assign resp_id_o    = mem_id_q[rd_ptr_q];
    assign resp_data_o  = mem_data_q[rd_ptr_q];
    assign pop          = resp_valid_o & resp_ready_i;
    assign pipe_valid   = stage_valid[LAT-1];

    // Credits: every issued op owns a FIFO slot from issue until it is popped.
    assign occ = (CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(stage_valid[0])
               + (CNT_W+1)'(stage_valid[1]);
    assign issue_ok = rst_n & ((occ < (CNT_W+1)'(FIFO_DEPTH)) |
                               ((occ == (CNT_W+1)'(FIFO_DEPTH)) & pop));

    // Round-robin search starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(N_REQ)) cand = cand - (TAG_W+1)'(N_REQ);
            if (!grant_found && req_valid_i[cand[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TAG_W-1:0];
            end
        end
    end

    assign accept      = grant_found & issue_ok;
    assign req_ready_o = accept ? (N_REQ'(1) << grant_idx) : '0;
    assign rr_d        = !accept ? rr_q :
                         (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (TAG_W'(i) == grant_idx) begin
                sel_a = req_a_i[i*DATA_W +: DATA_W];
                sel_b = req_b_i[i*DATA_W +: DATA_W];
                sel_c = req_c_i[i*DATA_W +: DATA_W];
            end
        end
    end

    mac_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (accept),
        .in_tag_i      (grant_idx),
        .a_i           (sel_a),
        .b_i           (sel_b),
        .c_i           (sel_c),
        .stage_valid_o (stage_valid),
        .out_tag_o     (pipe_tag),
        .out_data_o    (pipe_data)
    );

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (pipe_valid)
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({pipe_valid, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_id_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (pipe_valid) begin
                mem_id_q[wr_ptr_q]   <= pipe_tag;
                mem_data_q[wr_ptr_q] <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed and random checks of the shared multiply-add arbiter.
module tb_mac_share_arbiter;
    import mac_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;

    int n_cmp = 0;
    int n_bad = 0;
    resp_t exp_q[$];

    mac_share_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_c_i      (req_c),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mac_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        logic [15:0] full;
        full = {8'h00, a} * {8'h00, b} + {8'h00, c};
        return full[7:0];
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
    endtask

    // Requester i carries a=i+1, b=i+2, c=i -> results 2, 7, 14, 23.
    task automatic load_all();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'(i + 2), 8'(i));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, output logic [1:0] gid,
                           output logic [7:0] gdata, output bit got);
        bit acc;
        acc = 1'b0;
        got = 1'b0;
        gid = '0;
        gdata = '0;
        @(posedge clk); #1;
        set_req(id, a, b, c);
        req_valid = '0;
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin acc = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = '0;
        if (acc) begin
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (resp_valid) begin gid = resp_id; gdata = resp_data; got = 1'b1; break; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        #3;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id got %0d want 0", resp_id); end
        n_cmp++; if (resp_data !== 8'd0) begin n_bad++; $display("FAIL reset_resp_data got %0d want 0", resp_data); end
        do_reset();
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_req(0, 8'd3, 8'd4, 8'd5);
        req_valid = 4'b0001; resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_k got %b want 0", resp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_k1 got %b want 0", resp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", resp_valid); end
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL single_id got %0d want 0", resp_id); end
        n_cmp++; if (resp_data !== 8'd17) begin n_bad++; $display("FAIL single_data got %0d want 17", resp_data); end
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_popped got %b want 0", resp_valid); end
    endtask

    task automatic test_wrap();
        logic [1:0] gid; logic [7:0] gd; bit got;
        run_one(2, 8'd16, 8'd16, 8'd1, gid, gd, got);
        n_cmp++; if (!got || gid !== 2'd2 || gd !== 8'd1) begin n_bad++; $display("FAIL wrap_16x16p1 got=%0b id=%0d data=%0d want id=2 data=1", got, gid, gd); end
        run_one(3, 8'd255, 8'd255, 8'd0, gid, gd, got);
        n_cmp++; if (!got || gid !== 2'd3 || gd !== 8'd1) begin n_bad++; $display("FAIL wrap_255x255 got=%0b id=%0d data=%0d want id=3 data=1", got, gid, gd); end
    endtask

    task automatic test_round_robin();
        int exp_rdy[9];
        int exp_id[9];
        int exp_dat[4];
        exp_rdy = '{1, 2, 4, 8, 1, 2, 0, 0, 0};
        exp_id  = '{-1, -1, -1, 0, 1, 2, 3, 0, 1};
        exp_dat = '{2, 7, 14, 23};
        do_reset();
        @(posedge clk); #1;
        load_all();
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'(exp_rdy[n])) begin n_bad++; $display("FAIL rr_grant n=%0d got %b want %b", n, req_ready, 4'(exp_rdy[n])); end
            if (exp_id[n] < 0) begin
                n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_early_resp n=%0d got %b want 0", n, resp_valid); end
            end else begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(exp_id[n]) || resp_data !== 8'(exp_dat[exp_id[n]])) begin
                    n_bad++; $display("FAIL rr_resp n=%0d got v=%b id=%0d data=%0d want v=1 id=%0d data=%0d", n, resp_valid, resp_id, resp_data, exp_id[n], exp_dat[exp_id[n]]);
                end
            end
            @(posedge clk); #1;
            if (n == 5) req_valid = '0;
        end
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== ((n % 2 == 0) ? 4'b0010 : 4'b1000)) begin n_bad++; $display("FAIL rr_alt n=%0d got %b want %b", n, req_ready, (n % 2 == 0) ? 4'b0010 : 4'b1000); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int exp_rdy[11];
        int exp_id[11];
        int exp_dat[4];
        exp_rdy = '{1, 2, 4, 0, 0, 0, 8, 1, 2, 4, 8};
        exp_id  = '{-1, -1, -1, 0, 0, 0, 0, 1, 2, 3, 0};
        exp_dat = '{2, 7, 14, 23};
        do_reset();
        @(posedge clk); #1;
        load_all();
        req_valid = 4'b1111; resp_ready = 1'b0;
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'(exp_rdy[n])) begin n_bad++; $display("FAIL bp_grant n=%0d got %b want %b", n, req_ready, 4'(exp_rdy[n])); end
            if (exp_id[n] < 0) begin
                n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_early_resp n=%0d got %b want 0", n, resp_valid); end
            end else begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(exp_id[n]) || resp_data !== 8'(exp_dat[exp_id[n]])) begin
                    n_bad++; $display("FAIL bp_resp n=%0d got v=%b id=%0d data=%0d want v=1 id=%0d data=%0d", n, resp_valid, resp_id, resp_data, exp_id[n], exp_dat[exp_id[n]]);
                end
            end
            @(posedge clk); #1;
            if (n == 5) resp_ready = 1'b1;
        end
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [1:0] gid; logic [7:0] gd; bit got;
        int stale;
        do_reset();
        @(posedge clk); #1;
        set_req(0, 8'd1, 8'd1, 8'd1);
        req_valid = 4'b0001; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 8'd2) begin n_bad++; $display("FAIL mid_preload got v=%b data=%0d want v=1 data=2", resp_valid, resp_data); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_id !== 2'd0 || resp_data !== 8'd0) begin n_bad++; $display("FAIL mid_resp_payload got id=%0d data=%0d want 0/0", resp_id, resp_data); end
        @(posedge clk); #1;
        req_valid = '0; resp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_one(0, 8'd2, 8'd5, 8'd0, gid, gd, got);
        n_cmp++; if (!got || gid !== 2'd0 || gd !== 8'd10) begin n_bad++; $display("FAIL mid_after_release got=%0b id=%0d data=%0d want id=0 data=10", got, gid, gd); end
        stale = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale got %0d extra responses want 0", stale); end
    endtask

    task automatic test_random_stress();
        resp_t e, f;
        int gi;
        do_reset();
        for (int cyc = 0; cyc < 10010; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 10000) begin
                req_valid = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++)
                    set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                resp_ready = ($urandom_range(0, 9) < 7);
            end else begin
                req_valid = '0;
                resp_ready = 1'b1;
            end
            @(negedge clk);
            n_cmp++;
            if (((req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~req_valid) != 4'd0)) begin
                n_bad++; $display("FAIL stress_onehot cyc=%0d ready=%b valid=%b", cyc, req_ready, req_valid);
            end
            n_cmp++;
            if (dut.occ > 3 || (dut.pipe_valid && dut.fifo_cnt_q == 2'd3 && !dut.pop)) begin
                n_bad++; $display("FAIL stress_credit cyc=%0d occ=%0d cnt=%0d push=%b pop=%b", cyc, dut.occ, dut.fifo_cnt_q, dut.pipe_valid, dut.pop);
            end
            if (req_ready != 4'd0) begin
                gi = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
                e.id   = 2'(gi);
                e.data = mac_f(req_a[gi*8 +: 8], req_b[gi*8 +: 8], req_c[gi*8 +: 8]);
                exp_q.push_back(e);
            end
            if (resp_valid && resp_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL stress_unexpected cyc=%0d id=%0d data=%0d want no response", cyc, resp_id, resp_data);
                end else begin
                    f = exp_q.pop_front();
                    if (resp_id !== f.id || resp_data !== f.data) begin
                        n_bad++; $display("FAIL stress_resp cyc=%0d got id=%0d data=%0d want id=%0d data=%0d", cyc, resp_id, resp_data, f.id, f.data);
                    end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stress_lost got %0d undelivered want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
